// File: rtl/pipeline_mem_arbiter_if.sv
// Bus bundle between the IF/DM pipeline stages, the arbiter and the memory macro.
// The slave view is the arbiter. The master view is whatever drives the requests
// and models the memory.
interface pipeline_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // data-memory port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  // memory macro port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between the IF and DM stages.
// DM has priority over IF. After STARVE_MAX lost arbitrations in a row, IF is
// forced to win once. Only one transaction is outstanding at a time.
//
// state | meaning
// IDLE  | sample requests, arbitrate, issue mem_en and gnt on the winning edge
// WAIT  | count down the memory latency, then return data/ack to the owner
module pipeline_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_mem_arbiter_if.slave bus
);

  localparam int LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                owner_dm;
  logic                owner_we;

  logic                any_req;
  logic                if_wins;

  // Winner selection: DM by default, IF when alone or when it has starved long enough.
  always_comb begin
    any_req = bus.if_req | bus.dm_req;
    if_wins = 1'b0;
    if (bus.if_req && (!bus.dm_req || (starve_cnt == STARVE_TOP))) begin
      if_wins = 1'b1;
    end
  end

  // Control FSM with registered outputs. Strobes default low, so every pulse lasts one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      starve_cnt    <= '0;
      owner_dm      <= 1'b0;
      owner_we      <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_gnt    <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_gnt    <= 1'b0;
      bus.dm_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= WAIT;
            bus.busy   <= 1'b1;
            lat_cnt    <= LAT_LOAD;
            owner_dm   <= !if_wins;
            owner_we   <= !if_wins && bus.dm_we;
            bus.mem_en <= 1'b1;
            bus.mem_we <= !if_wins && bus.dm_we;
            bus.if_gnt <= if_wins;
            bus.dm_gnt <= !if_wins;
            if (if_wins) begin
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= '0;
            end else begin
              bus.mem_addr  <= bus.dm_addr;
              bus.mem_wdata <= bus.dm_wdata;
            end
            // A lost IF request counts toward starvation. A win or an absent IF request resets it.
            if (if_wins || !bus.if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_TOP) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end
        end

        WAIT: begin
          if (lat_cnt == '0) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (owner_dm) begin
              bus.dm_rvalid <= 1'b1;
              if (!owner_we) begin
                bus.dm_rdata <= bus.mem_rdata;
              end
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter with MEM_LAT=2 and STARVE_MAX=4.
// The memory model registers read data on the mem_en edge, so the data is
// present when the arbiter samples it MEM_LAT edges after arbitration.
module tb_pipeline_mem_arbiter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  pipeline_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  pipeline_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word-indexed memory model: 0x4 -> BEEF, 0x8 -> 1234, 0x10 -> CAFE
  logic [31:0] mem [16] = '{1: 32'h0000BEEF, 2: 32'h00001234, 4: 32'h0000CAFE, default: 32'h0};

  // memory macro: writes and reads happen on the mem_en edge
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},    bus.if_gnt,    0);
    chk({tag, "_if_rvalid"}, bus.if_rvalid, 0);
    chk({tag, "_if_rdata"},  bus.if_rdata,  0);
    chk({tag, "_dm_gnt"},    bus.dm_gnt,    0);
    chk({tag, "_dm_rvalid"}, bus.dm_rvalid, 0);
    chk({tag, "_dm_rdata"},  bus.dm_rdata,  0);
    chk({tag, "_mem_en"},    bus.mem_en,    0);
    chk({tag, "_mem_we"},    bus.mem_we,    0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_busy"},      bus.busy,      0);
  endtask

  initial begin
    int waited;
    logic exp_dm;

    vectors     = 0;
    miscompares = 0;
    bus.mem_rdata = '0;

    // reset asserted while the inputs toggle randomly
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.if_req   = 1'($urandom());
      bus.if_addr  = $urandom();
      bus.dm_req   = 1'($urandom());
      bus.dm_we    = 1'($urandom());
      bus.dm_addr  = $urandom();
      bus.dm_wdata = $urandom();
      tick();
    end
    chk_all_zero("rst");

    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0;
    reset = 1'b1;
    tick(); tick();
    chk_all_zero("post_rst");

    // single IF read of 0x8
    bus.if_req = 1; bus.if_addr = 32'h8;
    tick();
    chk("ifrd_gnt",      bus.if_gnt,   1);
    chk("ifrd_dm_gnt",   bus.dm_gnt,   0);
    chk("ifrd_mem_en",   bus.mem_en,   1);
    chk("ifrd_mem_we",   bus.mem_we,   0);
    chk("ifrd_mem_addr", bus.mem_addr, 32'h8);
    chk("ifrd_busy1",    bus.busy,     1);
    bus.if_req = 0;
    tick();
    chk("ifrd_gnt_drop", bus.if_gnt,    0);
    chk("ifrd_en_drop",  bus.mem_en,    0);
    chk("ifrd_busy2",    bus.busy,      1);
    chk("ifrd_early_rv", bus.if_rvalid, 0);
    tick();
    chk("ifrd_rvalid",   bus.if_rvalid, 1);
    chk("ifrd_rdata",    bus.if_rdata,  32'h1234);
    chk("ifrd_busy_off", bus.busy,      0);
    tick();
    chk("ifrd_rv_pulse", bus.if_rvalid, 0);
    chk("ifrd_hold",     bus.if_rdata,  32'h1234);

    // simultaneous requests: DM reads 0x10 first, IF reads 0x4 afterwards
    bus.if_req = 1; bus.if_addr = 32'h4;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h10;
    tick();
    chk("sim_dm_gnt",   bus.dm_gnt,   1);
    chk("sim_if_lose",  bus.if_gnt,   0);
    chk("sim_mem_addr", bus.mem_addr, 32'h10);
    bus.dm_req = 0;
    tick();
    tick();
    chk("sim_dm_rvalid", bus.dm_rvalid, 1);
    chk("sim_dm_rdata",  bus.dm_rdata,  32'hCAFE);
    chk("sim_if_wait",   bus.if_gnt,    0);
    tick();
    chk("sim_if_gnt",   bus.if_gnt,   1);
    chk("sim_if_addr",  bus.mem_addr, 32'h4);
    bus.if_req = 0;
    tick();
    tick();
    chk("sim_if_rvalid", bus.if_rvalid, 1);
    chk("sim_if_rdata",  bus.if_rdata,  32'hBEEF);
    tick();

    // starvation: both held high; order DM x4, IF, DM x4, IF with grants 3 cycles apart
    bus.if_req = 1; bus.dm_req = 1; bus.dm_we = 0;
    bus.if_addr = 32'h4; bus.dm_addr = 32'h10;
    for (int g = 0; g < 10; g++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!(bus.if_gnt || bus.dm_gnt) && waited < 10);
      exp_dm = ((g % 5) != 4);
      chk("starve_seen",  (bus.if_gnt || bus.dm_gnt), 1);
      chk("starve_owner", bus.dm_gnt, exp_dm);
      chk("starve_other", bus.if_gnt, !exp_dm);
      if (g > 0) chk("starve_spacing", waited, 3);
    end
    bus.if_req = 0; bus.dm_req = 0;
    tick();
    tick();
    chk("starve_last_rv", bus.if_rvalid, 1);
    tick();

    // DM write of A5A5A5A5 to 0x10; dm_rdata keeps the CAFE from the last DM read
    chk("wr_prior_rdata", bus.dm_rdata, 32'hCAFE);
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h10; bus.dm_wdata = 32'hA5A5A5A5;
    tick();
    chk("wr_gnt",       bus.dm_gnt,    1);
    chk("wr_mem_en",    bus.mem_en,    1);
    chk("wr_mem_we",    bus.mem_we,    1);
    chk("wr_mem_addr",  bus.mem_addr,  32'h10);
    chk("wr_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    bus.dm_req = 0; bus.dm_we = 0;
    tick();
    chk("wr_we_drop",  bus.mem_we,    0);
    chk("wr_en_drop",  bus.mem_en,    0);
    chk("wr_early_rv", bus.dm_rvalid, 0);
    tick();
    chk("wr_rvalid",  bus.dm_rvalid, 1);
    chk("wr_rdata",   bus.dm_rdata,  32'hCAFE);
    chk("wr_mem_cell", mem[4],       32'hA5A5A5A5);
    tick();

    // reset one cycle after an IF grant: the response is dropped
    bus.if_req = 1; bus.if_addr = 32'h8;
    tick();
    chk("rmid_gnt", bus.if_gnt, 1);
    bus.if_req = 0;
    tick();
    chk("rmid_busy_pre", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("rmid_busy",   bus.busy,      0);
    chk("rmid_rvalid", bus.if_rvalid, 0);
    chk("rmid_mem_en", bus.mem_en,    0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmid_no_rv_rst", bus.if_rvalid, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmid_no_rv_rel", bus.if_rvalid, 0);
      chk("rmid_idle",      bus.busy,      0);
    end

    // fresh IF read of 0x4 after reset release
    bus.if_req = 1; bus.if_addr = 32'h4;
    tick();
    chk("rec_gnt",  bus.if_gnt,   1);
    chk("rec_addr", bus.mem_addr, 32'h4);
    bus.if_req = 0;
    tick();
    tick();
    chk("rec_rvalid", bus.if_rvalid, 1);
    chk("rec_rdata",  bus.if_rdata,  32'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_arbiter.md
Name: pipeline_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch stage (IF) and memory-access stage (DM).
- Arbitrates requests with fixed DM-over-IF priority plus an IF anti-starvation counter.
- Sequences each access through a fixed-latency memory and returns the read data, or a write acknowledge, to the winning requester.
- Sits between the IF/MEM pipeline stages and the memory macro. It has one outstanding transaction at a time.

Parameters:
- ADDR_W, 32: address width of all address ports.
- DATA_W, 32: data width of all data ports.
- MEM_LAT, 2: memory read latency in clock edges from the edge that raises mem_en to the edge at which mem_rdata is sampled. Must be >=1.
- STARVE_MAX, 4: number of consecutive arbitrations IF may lose before it is forced to win.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  input  1  IF access request (read only).
- if_addr  input  ADDR_W  IF byte address.
- if_gnt  output  1  one-cycle pulse: IF request accepted.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DATA_W  IF read data; holds its last value.
- dm_req  input  1  DM access request.
- dm_we  input  1  DM write enable (1 = write, 0 = read).
- dm_addr  input  ADDR_W  DM byte address.
- dm_wdata  input  DATA_W  DM write data.
- dm_gnt  output  1  one-cycle pulse: DM request accepted.
- dm_rvalid  output  1  one-cycle pulse: read data valid, or write completed.
- dm_rdata  output  DATA_W  DM read data; holds its last value.
- mem_en  output  1  memory access strobe; high exactly one cycle per transaction.
- mem_we  output  1  memory write strobe; only high together with mem_en.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high while a transaction is outstanding (state WAIT).

Behaviour:
- All outputs are registered. Asynchronous reset forces every output to 0, state to IDLE, and both counters to 0.
- FSM has two states, IDLE and WAIT.
- IDLE: requests are sampled on each rising edge.
  - No request: stay in IDLE.
  - Otherwise: pick the winner, load lat_cnt = MEM_LAT-1, record owner, and go to WAIT.
  - On that same edge: drive mem_en=1; mem_addr and mem_wdata from the winner; mem_we = dm_we if DM wins, else 0; pulse the winner's gnt.
- Winner selection:
  - Only one requester: it wins.
  - Both requesting: DM wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when IF requested but lost.
  - Clears when IF wins, or when an arbitration happens with if_req=0.
- WAIT:
  - mem_en, mem_we and gnt drop on the first edge in WAIT.
  - lat_cnt decrements each edge.
  - On the edge where lat_cnt==0: capture mem_rdata into the owner's rdata (reads only; a DM write leaves dm_rdata unchanged), pulse the owner's rvalid, and return to IDLE.
- Latency:
  - gnt and mem_en rise on edge E1 (the arbitration edge).
  - rvalid rises on edge E1+MEM_LAT.
  - The earliest next grant is on edge E1+MEM_LAT+1, giving one transaction per MEM_LAT+1 cycles.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt is seen.
  - Drop req in the gnt cycle, or it is treated as a new request in the next IDLE cycle.
  - Requests arriving during WAIT are ignored until IDLE; they are not lost if held.
- busy = (state == WAIT).
- MEM_LAT=1: lat_cnt is loaded with 0, and data is captured on the edge immediately after the mem_en cycle.
- Reset asserted mid-transaction:
  - Immediately clears mem_en, mem_we, gnt and rvalid, and the outstanding response is discarded.
  - A write whose mem_en cycle already completed is not undone.
- Counter widths: $clog2(MEM_LAT) bits minimum 1 for lat_cnt, and $clog2(STARVE_MAX+1) bits for starve_cnt. No wrap is allowed; starve_cnt saturates.

Test Plan:
- Reset: drive reset=0 with random inputs -> all outputs 0, busy=0. Release reset -> still all 0 until a request arrives.
- IF read (MEM_LAT=2): if_req=1, if_addr=0x8, memory returns 0x00001234.
  - Required: if_gnt and mem_en=1 with mem_addr=0x8, mem_we=0 for one cycle after arbitration edge E1.
  - Required: if_rvalid pulse with if_rdata=0x00001234 after edge E1+2; busy high for 2 cycles.
- Simultaneous requests: if_req=dm_req=1 (dm read 0x10 -> 0xCAFE, if read 0x4 -> 0xBEEF).
  - Required: dm_gnt first; dm_rvalid with 0xCAFE.
  - Required: if_gnt on edge E1+3; if_rvalid with 0xBEEF on edge E1+5.
- Starvation (STARVE_MAX=4): dm_req and if_req held high continuously, re-requesting after each gnt.
  - Required: grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF...
- DM write: dm_we=1, dm_addr=0x10, dm_wdata=0xA5A5A5A5, prior dm_rdata=0xCAFE.
  - Required: one cycle of mem_en=mem_we=1 with that address and data.
  - Required: dm_rvalid pulse 2 edges later; dm_rdata stays 0xCAFE.
- Reset mid-op: assert reset one cycle after an IF grant.
  - Required: no if_rvalid ever; busy=0 at once. After release, a new IF read completes normally.
